// File: rtl/board_pkg.sv
// Board-wide timing constants and the button repeat FSM state type.
package board_pkg;

  localparam int CLK_HZ        = 24_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int REPEAT_500MS  = CLK_HZ / 2;
  localparam int REPEAT_100MS  = CLK_HZ / 10;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_fsm_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, counter debounce, edge pulses and
// optional auto-repeat of the press strobe while held.
module button_channel
  import board_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam int RPT_W   = cnt_w(RPT_MAX);

  localparam logic             PIN_IDLE = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(REPEAT_PERIOD - 1);

  logic             s1, s2, lvl;
  logic             accept, rise, fall;
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  btn_fsm_t         state;

  assign lvl    = (ACTIVE_LOW != 0) ? ~s2 : s2;
  assign accept = (lvl != level) && (db_cnt == DB_LAST);
  assign rise   = accept &  lvl;
  assign fall   = accept & ~lvl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1            <= PIN_IDLE;
      s2            <= PIN_IDLE;
      level         <= 1'b0;
      db_cnt        <= '0;
      rpt_cnt       <= '0;
      state         <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;

      // Any sample matching the accepted level restarts the persistence count.
      if (lvl == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level  <= lvl;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      press_pulse   <= rise;
      release_pulse <= fall;

      // A release wins over a repeat tick landing on the same cycle.
      if (REPEAT_EN == 0 || fall) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (rise) begin
            state   <= DELAY;
            rpt_cnt <= '0;
          end
          DELAY: if (rpt_cnt == RD_LAST) begin
            press_pulse <= 1'b1;
            rpt_cnt     <= '0;
            state       <= REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
          REPEAT: if (rpt_cnt == RP_LAST) begin
            press_pulse <= 1'b1;
            rpt_cnt     <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
          default: begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw push-button pins into debounced levels and single-cycle
// press/release strobes; one independent channel per button.
module button_conditioner
  import board_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] push_button,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .pin           (push_button[g]),
      .level         (btn_level[g]),
      .press_pulse   (btn_press[g]),
      .release_pulse (btn_release[g])
    );
  end

endmodule
